// File: rtl/ysyx_23060203_axi_sram_if.sv
// AXI4-Lite bus bundle between the LSU data port (master) and the SRAM model (slave).
interface ysyx_23060203_axi_sram_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_23060203_axi_sram.sv
// Word-addressed SRAM behind an AXI4-Lite slave port. Independent read and
// write engines, programmable response latency, byte strobes, DECERR outside
// the mapped window.
//
// state  | meaning
// R_IDLE | arready high, waiting for an AR handshake
// R_WAIT | read latency countdown
// R_RESP | rvalid high, rdata/rresp held until rready
// W_IDLE | collecting AW and W in either order
// W_WAIT | write latency countdown, nothing committed yet
// W_RESP | write committed on entry, bvalid high until bready
module ysyx_23060203_axi_sram #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          R_DELAY     = 0,
  parameter int          W_DELAY     = 0
) (
  input logic clock,
  input logic reset,
  ysyx_23060203_axi_sram_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam int RC_W = (R_DELAY > 1) ? $clog2(R_DELAY) : 1;
  localparam int WC_W = (W_DELAY > 1) ? $clog2(W_DELAY) : 1;
  localparam logic [RC_W-1:0] R_LOAD = RC_W'((R_DELAY > 0) ? R_DELAY - 1 : 0);
  localparam logic [WC_W-1:0] W_LOAD = WC_W'((W_DELAY > 0) ? W_DELAY - 1 : 0);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------- read engine ----------------
  r_state_t         r_state, r_next;
  logic [RC_W-1:0]  r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_ok;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;

  logic [31:0]      r_off;
  logic             r_dec_ok;
  logic [IDX_W-1:0] r_dec_idx;
  logic             ar_hs;
  logic [IDX_W-1:0] r_fetch_idx;
  logic             r_fetch_ok;

  assign r_off     = bus.araddr - ADDR_BASE;
  assign r_dec_ok  = (bus.araddr >= ADDR_BASE) && ({1'b0, r_off} < SPAN);
  assign r_dec_idx = r_off[IDX_W+1:2];
  assign ar_hs     = (r_state == R_IDLE) && bus.arvalid;

  // With no read delay the fetch happens on the AR edge itself, before the
  // latched index exists, so the fetch takes the live decode in that case.
  assign r_fetch_idx = (r_state == R_IDLE) ? r_dec_idx : r_idx;
  assign r_fetch_ok  = (r_state == R_IDLE) ? r_dec_ok  : r_ok;

  // Read next-state decode.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (bus.arvalid) r_next = (R_DELAY > 0) ? R_WAIT : R_RESP;
      R_WAIT: if (r_cnt == '0) r_next = R_RESP;
      R_RESP: if (bus.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read state, latency counter, captured address and registered response.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_ok    <= 1'b0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_idx <= r_dec_idx;
        r_ok  <= r_dec_ok;
        r_cnt <= R_LOAD;
      end else if ((r_state == R_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if ((r_state != R_RESP) && (r_next == R_RESP)) begin
        rdata_q <= r_fetch_ok ? mem[r_fetch_idx] : '0;
        rresp_q <= r_fetch_ok ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  assign bus.arready = (r_state == R_IDLE);
  assign bus.rvalid  = (r_state == R_RESP);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  // ---------------- write engine ----------------
  w_state_t         w_state, w_next;
  logic [WC_W-1:0]  w_cnt;
  logic             aw_held, w_held;
  logic [31:0]      aw_q, wdata_q;
  logic [3:0]       wstrb_q;
  logic [1:0]       bresp_q;

  logic             aw_hs, w_hs, w_both;
  logic [31:0]      w_addr_eff, w_data_eff;
  logic [3:0]       w_strb_eff;
  logic [31:0]      w_off;
  logic             w_dec_ok;
  logic [IDX_W-1:0] w_dec_idx;
  logic             w_enter_resp;
  logic             w_commit;

  assign aw_hs  = (w_state == W_IDLE) && !aw_held && bus.awvalid;
  assign w_hs   = (w_state == W_IDLE) && !w_held && bus.wvalid;
  assign w_both = (aw_held || aw_hs) && (w_held || w_hs);

  // The second half of a write may arrive on the same edge that commits it
  // (no delay), so the commit uses whichever copy is current.
  assign w_addr_eff = aw_held ? aw_q : bus.awaddr;
  assign w_data_eff = w_held ? wdata_q : bus.wdata;
  assign w_strb_eff = w_held ? wstrb_q : bus.wstrb;

  assign w_off     = w_addr_eff - ADDR_BASE;
  assign w_dec_ok  = (w_addr_eff >= ADDR_BASE) && ({1'b0, w_off} < SPAN);
  assign w_dec_idx = w_off[IDX_W+1:2];

  assign w_enter_resp = (w_state != W_RESP) && (w_next == W_RESP);
  assign w_commit     = !reset && w_enter_resp && w_dec_ok;

  // Write next-state decode.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (w_both) w_next = (W_DELAY > 0) ? W_WAIT : W_RESP;
      W_WAIT: if (w_cnt == '0) w_next = W_RESP;
      W_RESP: if (bus.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write state, capture flags/registers, latency counter and response.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_q    <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if ((w_state == W_RESP) && bus.bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_q    <= bus.awaddr;
        end
        if (w_hs) begin
          w_held  <= 1'b1;
          wdata_q <= bus.wdata;
          wstrb_q <= bus.wstrb;
        end
      end
      if ((w_state == W_IDLE) && (w_next == W_WAIT)) begin
        w_cnt <= W_LOAD;
      end else if ((w_state == W_WAIT) && (w_cnt != '0)) begin
        w_cnt <= w_cnt - 1'b1;
      end
      if (w_enter_resp) begin
        bresp_q <= w_dec_ok ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  // Byte-strobed array update; contents are deliberately outside reset.
  always_ff @(posedge clock) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb_eff[i]) mem[w_dec_idx][8*i +: 8] <= w_data_eff[8*i +: 8];
      end
    end
  end

  assign bus.awready = (w_state == W_IDLE) && !aw_held;
  assign bus.wready  = (w_state == W_IDLE) && !w_held;
  assign bus.bvalid  = (w_state == W_RESP);
  assign bus.bresp   = bresp_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{r_off[31:IDX_W+2], r_off[1:0], w_off[31:IDX_W+2], w_off[1:0]};

endmodule

// File: tb/tb_ysyx_23060203_axi_sram.sv
// Bench for ysyx_23060203_axi_sram: one instance with zero latency, one with
// R_DELAY=2 / W_DELAY=3, sharing bus stimulus and selected by sel.
module tb_ysyx_23060203_axi_sram;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        arvalid, awvalid, wvalid, rready, bready, sel;

  ysyx_23060203_axi_sram_if ifa ();
  ysyx_23060203_axi_sram_if ifb ();

  assign ifa.araddr  = araddr;   assign ifb.araddr  = araddr;
  assign ifa.awaddr  = awaddr;   assign ifb.awaddr  = awaddr;
  assign ifa.wdata   = wdata;    assign ifb.wdata   = wdata;
  assign ifa.wstrb   = wstrb;    assign ifb.wstrb   = wstrb;
  assign ifa.rready  = rready;   assign ifb.rready  = rready;
  assign ifa.bready  = bready;   assign ifb.bready  = bready;
  assign ifa.arvalid = arvalid & ~sel;  assign ifb.arvalid = arvalid & sel;
  assign ifa.awvalid = awvalid & ~sel;  assign ifb.awvalid = awvalid & sel;
  assign ifa.wvalid  = wvalid  & ~sel;  assign ifb.wvalid  = wvalid  & sel;

  wire        m_arready = sel ? ifb.arready : ifa.arready;
  wire        m_awready = sel ? ifb.awready : ifa.awready;
  wire        m_wready  = sel ? ifb.wready  : ifa.wready;
  wire        m_rvalid  = sel ? ifb.rvalid  : ifa.rvalid;
  wire        m_bvalid  = sel ? ifb.bvalid  : ifa.bvalid;
  wire [31:0] m_rdata   = sel ? ifb.rdata   : ifa.rdata;
  wire [1:0]  m_rresp   = sel ? ifb.rresp   : ifa.rresp;
  wire [1:0]  m_bresp   = sel ? ifb.bresp   : ifa.bresp;

  ysyx_23060203_axi_sram #(.R_DELAY(0), .W_DELAY(0)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa.slave));
  ysyx_23060203_axi_sram #(.R_DELAY(2), .W_DELAY(3)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb.slave));

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] rd_q [$];
  logic [1:0]  wr_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er, input int lat);
    int n;
    logic [1:0] e;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    wr_q.push_back(er);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!m_bvalid && n < 40) begin tick(); n++; end
    chk("wr_latency", 32'(n), 32'(lat));
    e = wr_q.pop_front();
    chk("bresp", 32'(m_bresp), 32'(e));
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                         input int lat);
    int n;
    logic [33:0] e;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    rd_q.push_back({er, ed});
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!m_rvalid && n < 40) begin tick(); n++; end
    chk("rd_latency", 32'(n), 32'(lat));
    e = rd_q.pop_front();
    chk("rdata", m_rdata, e[31:0]);
    chk("rresp", 32'(m_rresp), 32'(e[33:32]));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] re;
    logic [1:0]  we;
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1; bready = 1'b1; sel = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_arready", 32'(m_arready), 32'd1);
      chk("rst_awready", 32'(m_awready), 32'd1);
      chk("rst_wready",  32'(m_wready),  32'd1);
      chk("rst_rvalid",  32'(m_rvalid),  32'd0);
      chk("rst_bvalid",  32'(m_bvalid),  32'd0);
      chk("rst_rdata",   m_rdata,        32'd0);
      chk("rst_rresp",   32'(m_rresp),   32'd0);
      chk("rst_bresp",   32'(m_bresp),   32'd0);
    end
    sel = 1'b0;
    tick();

    // zero-latency instance
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 0);
    do_read (32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);
    do_write(32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00, 0);
    do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'b00, 0);
    do_read (32'h8000_0020, 32'h11BB_33DD, 2'b00, 0);
    do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, 2'b00, 0);
    do_read (32'h8000_0023, 32'h11BB_33DD, 2'b00, 0);
    do_write(32'h8000_0FFC, 32'h600D_0FFC, 4'hF, 2'b00, 0);
    do_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 2'b00, 0);
    do_read (32'h8000_1000, 32'h0000_0000, 2'b11, 0);
    do_write(32'h7FFF_FFFC, 32'hBADB_AD00, 4'hF, 2'b11, 0);
    do_read (32'h8000_0000, 32'hCAFE_F00D, 2'b00, 0);
    do_read (32'h8000_0FFC, 32'h600D_0FFC, 2'b00, 0);

    // read fetch and write commit on the same edge
    do_write(32'h8000_0030, 32'h0, 4'hF, 2'b00, 0);
    araddr = 32'h8000_0030; arvalid = 1'b1;
    awaddr = 32'h8000_0030; wdata = 32'h5555_5555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    rd_q.push_back({2'b00, 32'h0});
    wr_q.push_back(2'b00);
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("cf_rvalid", 32'(m_rvalid), 32'd1);
    chk("cf_bvalid", 32'(m_bvalid), 32'd1);
    re = rd_q.pop_front();
    chk("cf_rdata", m_rdata, re[31:0]);
    we = wr_q.pop_front();
    chk("cf_bresp", 32'(m_bresp), 32'(we));
    tick();
    do_read(32'h8000_0030, 32'h5555_5555, 2'b00, 0);

    // delayed instance: AW and W in separate cycles, bready held off
    sel = 1'b1;
    tick();
    awaddr = 32'h8000_0040; wdata = 32'h0BAD_CAFE; wstrb = 4'hF; bready = 1'b0;
    wr_q.push_back(2'b00);
    for (int c = 1; c <= 24; c++) begin
      chk("dc_wready",  32'(m_wready),  32'((c <= 5) || (c >= 22)));
      chk("dc_awready", 32'(m_awready), 32'((c <= 9) || (c >= 22)));
      chk("dc_bvalid",  32'(m_bvalid),  32'((c >= 13) && (c <= 21)));
      if (c == 13) begin
        we = wr_q.pop_front();
        chk("dc_bresp", 32'(m_bresp), 32'(we));
      end
      wvalid  = (c == 5);
      awvalid = (c == 9);
      bready  = (c >= 21);
      tick();
    end
    wvalid = 1'b0; awvalid = 1'b0; bready = 1'b1;
    do_read(32'h8000_0040, 32'h0BAD_CAFE, 2'b00, 2);

    // reset while a write is still counting down
    do_write(32'h8000_0044, 32'h1234_5678, 4'hF, 2'b00, 3);
    awaddr = 32'h8000_0044; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("rs_bvalid",  32'(m_bvalid),  32'd0);
      chk("rs_awready", 32'(m_awready), 32'd1);
      chk("rs_wready",  32'(m_wready),  32'd1);
      chk("rs_arready", 32'(m_arready), 32'd1);
      tick();
    end
    do_read(32'h8000_0044, 32'h1234_5678, 2'b00, 2);

    // zero-latency array survives reset
    sel = 1'b0;
    tick();
    do_read(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
